pwm_generator: RTL and testbench
================================

PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of duty_cycle and of the internal period counter; the block SHALL be verified at WIDTH=8.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous and active-high.
REQ-004 Port: duty_cycle  input  WIDTH  requested high time per period, in clock cycles; 0 = always low, 2^WIDTH-1 (255) = always high.
REQ-005 Port: pwm_out  output  1  registered PWM waveform.

Function
REQ-006 The block SHALL contain a WIDTH-bit period counter cnt counting 0,1,...,MAX-1 and wrapping MAX-1 -> 0, where MAX = 2^WIDTH-1 (255); period is exactly 255 clk cycles.
REQ-007 cnt SHALL never take the value 2^WIDTH-1; wrap SHALL be forced by comparison, not natural overflow.
REQ-008 On every rising clk edge with reset low, pwm_out SHALL be loaded with (cnt < duty_cycle), using the pre-edge cnt and the duty_cycle sampled at that edge (unsigned compare).
REQ-009 Output latency: pwm_out SHALL reflect a duty_cycle change one clk edge after the change is sampled; no period-boundary shadowing.
REQ-010 Duty 0 SHALL keep pwm_out low on every cycle.
REQ-011 Duty 255 SHALL keep pwm_out high on every cycle, including the cycle with cnt = 254.
REQ-012 For 0 < D < 255 held constant, each 255-cycle period SHALL contain exactly D consecutive high cycles followed by 255-D low cycles.
REQ-013 pwm_out SHALL be driven directly from a flip-flop, with no combinational path from duty_cycle to pwm_out.
REQ-014 duty_cycle changes mid-period SHALL take effect at the next edge without resetting cnt; a glitch-free period is not required.
REQ-015 The counter SHALL advance every cycle regardless of duty_cycle value.

Reset
REQ-016 While reset is high, cnt SHALL be 0 and pwm_out SHALL be 0, asynchronously to clk.
REQ-017 After reset deasserts, the first rising edge SHALL compute pwm_out from cnt=0 and advance cnt to 1.
REQ-018 Reset asserted mid-period SHALL immediately force pwm_out to 0 and restart the period at cnt=0 on release.

Verification
REQ-019 Reset then duty=0 held 600 cycles -> pwm_out 0 on every cycle.
REQ-020 Reset, duty=64 held from release -> after edge k (k>=1), pwm_out = ((k-1) mod 255) < 64; 64 high then 191 low per period, repeated over 3 periods.
REQ-021 duty=128 then duty=192 for full periods -> 128 high / 127 low, then 192 high / 63 low per 255 cycles.
REQ-022 duty=255 held 600 cycles -> pwm_out 1 on every cycle after the first edge, including cnt=254 edges.
REQ-023 duty=64 with cnt near 30, switch to duty=0 -> pwm_out 0 from the next edge; switch back to 64 at cnt=10 -> pwm_out 1 from the next edge.
REQ-024 Assert reset asynchronously between edges with pwm_out=1 -> pwm_out 0 before the next clk edge; after release, cnt restarts at 0.

Source files
------------

// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_generator
//  Description : Free-running PWM generator. A WIDTH-bit period counter runs
//                0 .. 2^WIDTH-2 and wraps, giving a period of 2^WIDTH-1 clock
//                cycles. The output is high while the counter is below the
//                requested duty cycle, so duty 0 is always low and duty
//                2^WIDTH-1 is always high.
//  Ports       : clk        - clock, all state updates on the rising edge
//                reset      - asynchronous active-high reset
//                duty_cycle - high time per period, in clock cycles
//                pwm_out    - registered PWM waveform
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] duty_cycle,
    output logic             pwm_out
);

    // Last counter value before wrapping: 2^WIDTH-2. The all-ones value is
    // never reached, so the top duty code compares true on every cycle.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             pwm_q;
    logic             pwm_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        // Uses the pre-edge count and the duty value sampled this edge.
        pwm_d = (cnt_q < duty_cycle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_generator
//  Description : Self-checking bench for pwm_generator. A reference model
//                predicts the output from the number of edges since reset
//                (position in period = edges mod 255).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_generator;

    localparam int WIDTH  = 8;
    localparam int PERIOD = 255;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] duty_cycle;
    logic             pwm_out;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;   // rising edges since reset release

    pwm_generator #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .duty_cycle (duty_cycle),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] duty;
        int               exp_highs;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t edges=%0d", name, act, exp, $time, edges);
        end
    endtask

    // Output after an edge whose pre-edge period position is k.
    function automatic logic model(input int k, input int d);
        return (k % PERIOD) < d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1 chk("reset_pwm", {31'd0, pwm_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        edges = 0;
    endtask

    task automatic step(input logic [WIDTH-1:0] d, output logic got);
        logic exp;
        duty_cycle = d;
        @(posedge clk);
        exp = model(edges, int'(d));
        edges++;
        #1;
        got = pwm_out;
        chk("pwm_model", {31'd0, pwm_out}, {31'd0, exp});
    endtask

    initial begin
        logic got;
        int   highs;
        int   first_low;

        vecs[0] = '{8'd0,   0};
        vecs[1] = '{8'd1,   1};
        vecs[2] = '{8'd64,  64};
        vecs[3] = '{8'd128, 128};
        vecs[4] = '{8'd192, 192};
        vecs[5] = '{8'd254, 254};
        vecs[6] = '{8'd255, 255};

        reset      = 1'b1;
        duty_cycle = '0;
        #1 chk("reset_state", {31'd0, pwm_out}, 32'd0);

        // Table: each duty held for 3 aligned periods; D high then low.
        foreach (vecs[v]) begin
            do_reset();
            for (int p = 0; p < 3; p++) begin
                highs     = 0;
                first_low = PERIOD;
                for (int i = 0; i < PERIOD; i++) begin
                    step(vecs[v].duty, got);
                    if (got) highs++;
                    else if (first_low == PERIOD) first_low = i;
                end
                chk("period_highs", highs, vecs[v].exp_highs);
                chk("high_run_len", first_low, vecs[v].exp_highs);
            end
        end

        // Long holds at the extremes, including cnt=254 edges.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(8'd0, got);
            chk("duty0_low", {31'd0, got}, 32'd0);
        end
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(8'd255, got);
            chk("duty255_high", {31'd0, got}, 32'd1);
        end

        // Mid-period duty changes take effect at the next edge.
        do_reset();
        for (int i = 0; i < 30; i++) step(8'd64, got);
        step(8'd0, got);
        chk("switch_to_0", {31'd0, got}, 32'd0);
        while ((edges % PERIOD) != 10) step(8'd0, got);
        step(8'd64, got);
        chk("switch_to_64", {31'd0, got}, 32'd1);
        for (int i = 0; i < 100; i++) step(8'd64, got);

        // Asynchronous reset between edges while the output is high.
        do_reset();
        for (int i = 0; i < 5; i++) step(8'd255, got);
        chk("pre_async_high", {31'd0, pwm_out}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("async_reset_low", {31'd0, pwm_out}, 32'd0);
        @(posedge clk);
        #1 chk("held_in_reset", {31'd0, pwm_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        edges = 0;
        for (int i = 0; i < 300; i++) step(8'd64, got);

        // Randomized duty changes against the model.
        do_reset();
        duty_cycle = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4000; i++) begin
            logic [WIDTH-1:0] d;
            d = duty_cycle;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       d = 8'd0;
                    1:       d = 8'd255;
                    default: d = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 799) == 0) do_reset();
            step(d, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
